multi_digit_seg_driver: RTL and testbench
=========================================

MULTI_DIGIT_SEG_DRIVER -- requirements
Module: multi_digit_seg_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of scanned digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 16: clock cycles each digit stays selected; legal range >= 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts every seg and dig_en bit at the outputs.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  1 = scan and drive display; 0 = outputs inactive, scan state held.
REQ-007 load  input  1  1 = capture data_in into the shadow register at this edge.
REQ-008 data_in  input  4*NUM_DIGITS  hex nibbles; nibble i = data_in[4i+3:4i]; nibble 0 is least significant.
REQ-009 lz_blank  input  1  1 = leading-zero suppression on.
REQ-010 seg  output  7  registered segment drive; seg[6..0] = a,b,c,d,e,f,g; logical 1 = segment lit.
REQ-011 dig_en  output  NUM_DIGITS  registered one-hot digit select; bit i drives digit i.

Function
REQ-012 SHALL hold the displayed value in a shadow register, written from data_in on any edge with load=1; decoding uses the new value from the next edge on.
REQ-013 SHALL run a prescaler 0..REFRESH_DIV-1 while enable=1; it wraps from REFRESH_DIV-1 to 0.
REQ-014 SHALL advance the digit index 0,1,..,NUM_DIGITS-1,0 on the prescaler wrap; REFRESH_DIV=1 advances every cycle; NUM_DIGITS=1 keeps the index at 0.
REQ-015 SHALL freeze both prescaler and digit index while enable=0.
REQ-016 SHALL register outputs with one cycle of latency: at each edge, seg and dig_en take the decode of the current index and shadow register.
REQ-017 SHALL decode each nibble to seg as follows: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
REQ-018 SHALL blank digit i (seg = 00, dig_en still asserted) when lz_blank=1 and nibbles i..NUM_DIGITS-1 are all zero, for i > 0 only.
REQ-019 SHALL never blank digit 0; value 0 with lz_blank=1 shows "0" on digit 0.
REQ-020 SHALL drive seg=00 and dig_en all 0 (logical) at the edge after enable is sampled 0.
REQ-021 SHALL give load a same-edge wrap no priority conflict: the shadow write and the index advance both take effect at that edge.
REQ-022 SHALL apply the ACTIVE_LOW inversion after the output registers' logical values, including reset values.

Reset
REQ-023 SHALL, at an edge with reset_n=0, clear the shadow register, prescaler and digit index to 0, and drive seg and dig_en inactive (logical 0).
REQ-024 SHALL let reset override load and enable at the same edge; reset mid-scan abandons the current digit.
REQ-025 SHALL start scanning at digit 0 with prescaler 0 on the first edge with reset_n=1 and enable=1.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-026 Reset: hold reset_n=0 for 2 cycles with enable=1 and load=1 -> seg=00, dig_en=0000; after release with load=0, digit 0 shows 7E.
REQ-027 Scan: load 16'h12AF, enable=1, lz_blank=0.
- Required sequence: dig_en 0001/seg 47 for 4 cycles, 0010/77 x4, 0100/6D x4, 1000/30 x4, then wrap to 0001/47.
REQ-028 Leading-zero suppression: load 16'h0050 with lz_blank=1 -> digits 3 and 2 show seg 00, digit 1 shows 5B, digit 0 shows 7E.
- Then load 16'h0000 -> only digit 0 lit, showing 7E.
REQ-029 ACTIVE_LOW=1 -> during reset, seg=7F and dig_en=1111; with value 8 on digit 0, seg=00 and dig_en=1110.
REQ-030 Enable/reset mid-scan:
- Drop enable while digit 2 is selected -> outputs inactive next cycle; re-enable -> digit 2 resumes with the remaining prescaler count.
- Pulse reset_n=0 while digit 2 is selected -> outputs inactive; after release, scan restarts at digit 0 showing 7E.
REQ-031 Load at wrap: change data_in with load=1 on the same edge the index moves 0->1 -> digit 1 immediately shows the new nibble.

Source files
------------

// File: rtl/multi_digit_seg_driver.sv
// Time-multiplexed hex driver for a common-select 7-segment display with
// leading-zero suppression and optional active-low output polarity.
module multi_digit_seg_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      4'hF:    s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic [PW-1:0]           pre_r;
  logic [IW-1:0]           idx_r;
  logic [6:0]              seg_r;
  logic [NUM_DIGITS-1:0]   dig_r;

  logic [3:0]              cur_nib_s;
  logic                    upper_nonzero_s;
  logic                    blank_s;
  logic [6:0]              seg_next_s;
  logic [NUM_DIGITS-1:0]   dig_next_s;

  // Decode the currently selected digit; a digit above 0 is blanked when it
  // and every more significant nibble are zero.
  always_comb begin
    cur_nib_s       = 4'h0;
    upper_nonzero_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_nib_s       = cur_nib_s | ((idx_r == IW'(i)) ? shadow_r[4*i +: 4] : 4'h0);
      upper_nonzero_s = upper_nonzero_s |
                        ((IW'(i) >= idx_r) && (shadow_r[4*i +: 4] != 4'h0));
    end
    blank_s    = lz_blank && (idx_r != {IW{1'b0}}) && !upper_nonzero_s;
    seg_next_s = blank_s ? 7'h00 : hex_to_seg(cur_nib_s);
    dig_next_s = NUM_DIGITS'(1) << idx_r;
  end

  // Shadow register, scan counters and registered logical outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_r <= '0;
      pre_r    <= '0;
      idx_r    <= '0;
      seg_r    <= 7'h00;
      dig_r    <= '0;
    end else begin
      if (load) begin
        shadow_r <= data_in;
      end else begin
        shadow_r <= shadow_r;
      end
      if (enable) begin
        seg_r <= seg_next_s;
        dig_r <= dig_next_s;
        if (pre_r == PRE_MAX) begin
          pre_r <= '0;
          idx_r <= (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + IW'(1);
        end else begin
          pre_r <= pre_r + PW'(1);
          idx_r <= idx_r;
        end
      end else begin
        seg_r <= 7'h00;
        dig_r <= '0;
        pre_r <= pre_r;
        idx_r <= idx_r;
      end
    end
  end

  // Polarity is applied after the registers so reset values invert as well.
  assign seg    = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign dig_en = (ACTIVE_LOW != 0) ? ~dig_r : dig_r;

endmodule

// File: tb/tb_multi_digit_seg_driver.sv
// Scoreboard bench: four differently parameterised drivers share one stimulus
// stream; a behavioural model queues expected outputs, a monitor checks them.
module tb_multi_digit_seg_driver;

  logic        clk = 1'b0;
  logic        reset_n, enable, load, lz_blank;
  logic [15:0] data_in;

  logic [6:0] seg0, seg1, seg2, seg3;
  logic [3:0] dig0, dig1;
  logic [2:0] dig2;
  logic [0:0] dig3;

  logic done_r = 1'b0;

  always #5 clk = ~clk;

  multi_digit_seg_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .data_in(data_in), .lz_blank(lz_blank), .seg(seg0), .dig_en(dig0));
  multi_digit_seg_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .data_in(data_in), .lz_blank(lz_blank), .seg(seg1), .dig_en(dig1));
  multi_digit_seg_driver #(.NUM_DIGITS(3), .REFRESH_DIV(1), .ACTIVE_LOW(0)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .data_in(data_in[11:0]), .lz_blank(lz_blank), .seg(seg2), .dig_en(dig2));
  multi_digit_seg_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .ACTIVE_LOW(0)) u3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .data_in(data_in[3:0]), .lz_blank(lz_blank), .seg(seg3), .dig_en(dig3));

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] dig;
  } exp_t;

  exp_t sb_q [4][$];

  int nd_c [4] = '{4, 4, 3, 1};
  int rd_c [4] = '{4, 4, 1, 3};
  int al_c [4] = '{0, 1, 0, 0};
  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int          m_pre    [4];
  int          m_idx    [4];
  logic [31:0] m_shadow [4];

  logic [6:0] act_seg [4];
  logic [7:0] act_dig [4];
  assign act_seg[0] = seg0;
  assign act_seg[1] = seg1;
  assign act_seg[2] = seg2;
  assign act_seg[3] = seg3;
  assign act_dig[0] = {4'h0, dig0};
  assign act_dig[1] = {4'h0, dig1};
  assign act_dig[2] = {5'h00, dig2};
  assign act_dig[3] = {7'h00, dig3};

  int n_checks = 0;
  int n_fail   = 0;

  // One clock of stimulus: predict every instance's outputs from the inputs
  // presented at this edge, then queue them once the edge has happened.
  task automatic cycle();
    exp_t        e [4];
    logic [31:0] mask, upper;
    for (int k = 0; k < 4; k++) begin
      mask = (32'h1 << (4 * nd_c[k])) - 32'h1;
      e[k] = '0;
      if (!reset_n) begin
        m_shadow[k] = 32'h0;
        m_pre[k]    = 0;
        m_idx[k]    = 0;
      end else begin
        if (enable) begin
          upper    = m_shadow[k] >> (4 * m_idx[k]);
          e[k].dig = 8'(1 << m_idx[k]);
          e[k].seg = (lz_blank && m_idx[k] > 0 && upper == 32'h0) ? 7'h00
                                                                  : seg_tab[upper % 16];
          m_pre[k] = m_pre[k] + 1;
          if (m_pre[k] == rd_c[k]) begin
            m_pre[k] = 0;
            m_idx[k] = (m_idx[k] + 1) % nd_c[k];
          end
        end
        if (load) m_shadow[k] = {16'h0, data_in} & mask;
      end
      if (al_c[k] != 0) begin
        e[k].seg = ~e[k].seg;
        e[k].dig = ~e[k].dig & 8'((1 << nd_c[k]) - 1);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) sb_q[k].push_back(e[k]);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_value(input logic [15:0] v);
    data_in = v;
    load    = 1'b1;
    cycle();
    load    = 1'b0;
  endtask

  // Monitor: compare every instance against the queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (sb_q[k].size() > 0) begin
        exp_t e;
        e = sb_q[k].pop_front();
        n_checks++;
        if (act_seg[k] !== e.seg || act_dig[k] !== e.dig) begin
          n_fail++;
          $display("FAIL inst%0d t=%0t: seg=%h dig_en=%b, required seg=%h dig_en=%b",
                   k, $time, act_seg[k], act_dig[k], e.seg, e.dig);
        end
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded time.
  initial begin
    #1000000;
    if (!done_r) begin
      n_fail++;
      $display("FAIL timeout t=%0t: stimulus did not finish in time", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    load     = 1'b1;
    lz_blank = 1'b0;
    data_in  = 16'hBEEF;
    run(2);
    n_checks++;
    if (seg0 !== 7'h00 || dig0 !== 4'h0 || seg1 !== 7'h7F || dig1 !== 4'hF) begin
      n_fail++;
      $display("FAIL reset state t=%0t: seg0=%h dig0=%b seg1=%h dig1=%b",
               $time, seg0, dig0, seg1, dig1);
    end
    reset_n = 1'b1;
    load    = 1'b0;
    run(6);

    // Load coinciding with the 0->1 digit advance.
    reset_n = 1'b0; run(1); reset_n = 1'b1;
    run(3);
    load_value(16'h9876);
    run(6);

    load_value(16'h12AF);
    run(20);

    lz_blank = 1'b1;
    load_value(16'h0050);
    run(20);
    load_value(16'h0000);
    run(20);
    load_value(16'h0800);
    run(16);

    lz_blank = 1'b0;
    load_value(16'h4321);
    run(9);
    enable = 1'b0; run(3);
    enable = 1'b1; run(10);
    run(1);
    reset_n = 1'b0; run(1);
    reset_n = 1'b1; run(20);

    for (int i = 0; i < 2000; i++) begin
      reset_n  = ($urandom_range(0, 99) != 0);
      enable   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 7) == 0);
      lz_blank = 1'($urandom);
      data_in  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      cycle();
    end

    @(negedge clk);
    #1;
    done_r = 1'b1;
    if (n_checks == 0) begin
      n_fail++;
      $display("FAIL no comparisons were evaluated");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
